// File: rtl/gige_log_pkg.sv
// Shared definitions for the GMII log framer: record header layout, flag bits and FSM states.
// The header byte order is fixed here so every consumer of the record stream agrees on it.
package gige_log_pkg;

    localparam int         LOG_HDR_BYTES = 8;
    localparam logic [7:0] LOG_MAGIC     = 8'hA5;
    localparam int         FLAG_TRUNC    = 0;
    localparam int         FLAG_DROP     = 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CAPTURE,
        ST_HDR,
        ST_DATA
    } log_state_t;

    // Header layout: magic, flags, length (big-endian), timestamp (big-endian).
    function automatic logic [7:0] hdr_byte(input logic [2:0]  idx,
                                            input logic [7:0]  magic,
                                            input logic [7:0]  flags,
                                            input logic [15:0] len,
                                            input logic [31:0] ts);
        logic [7:0] b;
        case (idx)
            3'd0:    b = magic;
            3'd1:    b = flags;
            3'd2:    b = len[15:8];
            3'd3:    b = len[7:0];
            3'd4:    b = ts[31:24];
            3'd5:    b = ts[23:16];
            3'd6:    b = ts[15:8];
            default: b = ts[7:0];
        endcase
        return b;
    endfunction

endpackage

// File: rtl/gmii_log_buf_ram.sv
// Frame buffer: simple dual-port RAM, one write port and one registered read port.
// The read register only updates on i_rd_en so a stalled output byte stays put.
module gmii_log_buf_ram #(
    parameter int AW = 11
) (
    input  logic          clock,
    input  logic          i_wr_en,
    input  logic [AW-1:0] i_wr_addr,
    input  logic [7:0]    i_wr_data,
    input  logic          i_rd_en,
    input  logic [AW-1:0] i_rd_addr,
    output logic [7:0]    o_rd_data
);

    logic [7:0] r_mem [0:(1<<AW)-1];
    logic [7:0] r_rd_data;

    always_ff @(posedge clock) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
        if (i_rd_en) begin
            r_rd_data <= r_mem[i_rd_addr];
        end
    end

    assign o_rd_data = r_rd_data;

endmodule

// File: rtl/gmii_log_framer.sv
// Captures one GMII log frame at a time and replays it as an 8-byte header plus payload record.
// Frames arriving while a record is being emitted are discarded whole and counted.
module gmii_log_framer
    import gige_log_pkg::*;
#(
    parameter int         BUF_AW = 11,
    parameter logic [7:0] MAGIC  = LOG_MAGIC
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        log_en,
    input  logic [7:0]  log_d,
    input  logic        log_frame_end,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [7:0]  out_d,
    output logic        out_last,
    output logic [15:0] drop_count
);

    if (BUF_AW < 1 || BUF_AW > 15) begin : g_bad_buf_aw
        $error("gmii_log_framer: BUF_AW must be in 1..15");
    end

    localparam logic [15:0] DEPTH    = 16'(1 << BUF_AW);
    localparam logic [2:0]  HDR_LAST = 3'(LOG_HDR_BYTES - 1);

    log_state_t        r_state, w_next;
    logic [31:0]       r_ts_cnt, r_ts;
    logic [15:0]       r_len, r_data_idx, r_drop_cnt;
    logic [2:0]        r_hdr_idx;
    logic [7:0]        r_flags, w_flags;
    logic              r_trunc, r_dropflag, r_discard;
    logic              w_wr_en, w_rd_en, w_drop, w_trunc_now, w_enter_hdr;
    logic [BUF_AW-1:0] w_wr_addr, w_rd_addr;
    logic [7:0]        w_rd_data;

    gmii_log_buf_ram #(.AW(BUF_AW)) u_buf (
        .clock     (clock),
        .i_wr_en   (w_wr_en),
        .i_wr_addr (w_wr_addr),
        .i_wr_data (log_d),
        .i_rd_en   (w_rd_en),
        .i_rd_addr (w_rd_addr),
        .o_rd_data (w_rd_data)
    );

    always_ff @(posedge clock) begin
        if (reset) r_state <= ST_IDLE;
        else       r_state <= w_next;
    end

    // The read port always fetches the byte after the one on out_d, so DATA streams at full rate.
    always_comb begin
        w_next    = r_state;
        out_valid = 1'b0;
        out_d     = 8'h00;
        out_last  = 1'b0;
        w_wr_en   = 1'b0;
        w_wr_addr = r_len[BUF_AW-1:0];
        w_rd_en   = 1'b0;
        w_rd_addr = r_data_idx[BUF_AW-1:0] + BUF_AW'(1);
        case (r_state)
            ST_IDLE: begin
                if (log_en && !r_discard) begin
                    w_wr_en   = 1'b1;
                    w_wr_addr = '0;
                    w_next    = log_frame_end ? ST_HDR : ST_CAPTURE;
                end
            end
            ST_CAPTURE: begin
                if (log_en) begin
                    w_wr_en = (r_len < DEPTH);
                    if (log_frame_end) w_next = ST_HDR;
                end
            end
            ST_HDR: begin
                out_valid = 1'b1;
                out_d     = hdr_byte(r_hdr_idx, MAGIC, r_flags, r_len, r_ts);
                if (out_ready && r_hdr_idx == HDR_LAST) begin
                    w_next    = ST_DATA;
                    w_rd_en   = 1'b1;
                    w_rd_addr = '0;
                end
            end
            default: begin
                out_valid = 1'b1;
                out_d     = w_rd_data;
                out_last  = (r_data_idx == r_len - 16'd1);
                if (out_ready) begin
                    w_rd_en = 1'b1;
                    if (out_last) w_next = ST_IDLE;
                end
            end
        endcase
    end

    assign w_drop      = log_en && !r_discard && (r_state == ST_HDR || r_state == ST_DATA);
    assign w_trunc_now = (r_state == ST_CAPTURE) && log_en && (r_len >= DEPTH);
    assign w_enter_hdr = (r_state != ST_HDR) && (w_next == ST_HDR);

    always_comb begin
        w_flags             = 8'h00;
        w_flags[FLAG_TRUNC] = r_trunc || w_trunc_now;
        w_flags[FLAG_DROP]  = r_dropflag;
    end

    // Flags are snapshotted on entry to HDR; drops seen from then on belong to the next record.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_ts_cnt   <= '0;
            r_ts       <= '0;
            r_len      <= '0;
            r_data_idx <= '0;
            r_hdr_idx  <= '0;
            r_flags    <= '0;
            r_trunc    <= 1'b0;
            r_dropflag <= 1'b0;
            r_discard  <= 1'b0;
            r_drop_cnt <= '0;
        end else begin
            r_ts_cnt <= r_ts_cnt + 32'd1;
            if (r_state == ST_IDLE && w_wr_en) begin
                r_len <= 16'd1;
                r_ts  <= r_ts_cnt;
            end
            if (r_state == ST_CAPTURE && w_wr_en) r_len <= r_len + 16'd1;
            if (w_trunc_now) r_trunc <= 1'b1;
            if (w_enter_hdr) begin
                r_hdr_idx  <= '0;
                r_flags    <= w_flags;
                r_dropflag <= 1'b0;
            end
            if (r_state == ST_HDR && out_ready) begin
                r_hdr_idx <= r_hdr_idx + 3'd1;
                if (r_hdr_idx == HDR_LAST) r_data_idx <= '0;
            end
            if (r_state == ST_DATA && out_ready) begin
                r_data_idx <= r_data_idx + 16'd1;
                if (out_last) r_trunc <= 1'b0;
            end
            if (w_drop) begin
                r_dropflag <= 1'b1;
                if (r_drop_cnt != 16'hFFFF) r_drop_cnt <= r_drop_cnt + 16'd1;
            end
            if (log_en && log_frame_end) r_discard <= 1'b0;
            else if (w_drop)             r_discard <= 1'b1;
        end
    end

    assign drop_count = r_drop_cnt;

endmodule

// File: tb/tb_gmii_log_framer.sv
// Directed bench for gmii_log_framer: frame table plus hand sequences for drop, stall and reset cases.
// Records are collected from the output handshake and compared against hand-built headers and payloads.
module tb_gmii_log_framer;

    logic        clock = 1'b0;
    logic        reset;
    logic        log_en;
    logic [7:0]  log_d;
    logic        log_frame_end;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_d;
    logic        out_last;
    logic [15:0] drop_count;

    int         testsRun    = 0;
    int         failCount   = 0;
    int         tbCycle     = 0;
    int         readyMode   = 0;
    int         recordsDone = 0;
    logic [7:0] gotD[$];
    bit         gotL[$];

    typedef struct {
        string      name;
        int         frameLen;
        int         stall;
        int         seed;
        int         expLen;
        logic [7:0] expFlags;
    } vec_t;

    vec_t vecs[6];

    always #5 clock = ~clock;

    gmii_log_framer #(.BUF_AW(11), .MAGIC(8'hA5)) dut (
        .clock         (clock),
        .reset         (reset),
        .log_en        (log_en),
        .log_d         (log_d),
        .log_frame_end (log_frame_end),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_d         (out_d),
        .out_last      (out_last),
        .drop_count    (drop_count)
    );

    always @(posedge clock) tbCycle <= reset ? 0 : tbCycle + 1;

    task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
        testsRun++;
        if (got !== exp) begin
            failCount++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    function automatic logic [7:0] pat(input int i, input int seed);
        return 8'(i * 5 + seed + (i >> 8));
    endfunction

    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clock);
            #1;
            case (readyMode)
                0:       out_ready = 1'b1;
                1:       out_ready = ($urandom_range(0, 1) == 1);
                default: out_ready = 1'b0;
            endcase
        end
    end

    // Collector: bytes presented with valid&&ready at the negedge transfer on the next posedge.
    initial begin
        bit         prevStall = 1'b0;
        logic [7:0] prevD     = 8'h00;
        bit         prevL     = 1'b0;
        forever begin
            @(negedge clock);
            if (reset) begin
                prevStall = 1'b0;
            end else begin
                if (prevStall)
                    checkOutput("stall_hold", 32'({out_valid, out_last, out_d}), 32'({1'b1, prevL, prevD}));
                if (out_valid && out_ready) begin
                    gotD.push_back(out_d);
                    gotL.push_back(out_last);
                    if (out_last) recordsDone++;
                end
                prevStall = out_valid && !out_ready;
                prevD     = out_d;
                prevL     = out_last;
            end
        end
    end

    task automatic applyStimulus(input int len, input int seed, output logic [31:0] ts);
        ts = '0;
        for (int i = 0; i < len; i++) begin
            @(negedge clock);
            if (i == 0) ts = 32'(tbCycle);
            log_en        = 1'b1;
            log_d         = pat(i, seed);
            log_frame_end = (i == len - 1);
        end
        @(negedge clock);
        log_en        = 1'b0;
        log_frame_end = 1'b0;
        log_d         = 8'h00;
    endtask

    task automatic waitRecords(input string name, input int target);
        for (int c = 0; c < 20000 && recordsDone < target; c++) @(negedge clock);
        @(negedge clock);
        checkOutput($sformatf("%s_record_done", name), 32'(recordsDone), 32'(target));
    endtask

    task automatic waitBytes(input string name, input int count);
        for (int c = 0; c < 5000 && gotD.size() < count; c++) @(negedge clock);
        checkOutput($sformatf("%s_bytes_seen", name), 32'(gotD.size() >= count), 32'd1);
    endtask

    task automatic checkRecord(input string name, input int expLen, input logic [7:0] expFlags,
                               input logic [31:0] ts, input int seed);
        int          n;
        int          bad;
        int          lastPos;
        int          lastCnt;
        logic [15:0] l;
        logic [7:0]  hdr [8];
        n   = gotD.size();
        l   = 16'(expLen);
        hdr = '{8'hA5, expFlags, l[15:8], l[7:0], ts[31:24], ts[23:16], ts[15:8], ts[7:0]};
        checkOutput($sformatf("%s_size", name), 32'(n), 32'(8 + expLen));
        if (n >= 8) begin
            for (int k = 0; k < 8; k++)
                checkOutput($sformatf("%s_hdr%0d", name, k), 32'(gotD[k]), 32'(hdr[k]));
        end
        bad = -1;
        for (int i = 0; i < expLen && 8 + i < n; i++)
            if (bad < 0 && gotD[8 + i] !== pat(i, seed)) bad = i;
        checkOutput($sformatf("%s_payload_first_bad", name), 32'(bad), 32'(-1));
        lastPos = -1;
        lastCnt = 0;
        for (int i = 0; i < n; i++)
            if (gotL[i]) begin
                lastPos = i;
                lastCnt++;
            end
        checkOutput($sformatf("%s_last_pos", name), 32'(lastPos), 32'(8 + expLen - 1));
        checkOutput($sformatf("%s_last_count", name), 32'(lastCnt), 32'd1);
        gotD.delete();
        gotL.delete();
    endtask

    initial begin
        logic [31:0] ts;
        int          target;
        #(900000);
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        logic [31:0] ts;
        int          target;

        vecs[0] = '{"one_byte",   1,    0, 17, 1,    8'h00};
        vecs[1] = '{"stall60",    60,   1, 3,  60,   8'h00};
        vecs[2] = '{"trunc2100",  2100, 0, 9,  2048, 8'h01};
        vecs[3] = '{"exact2048",  2048, 0, 21, 2048, 8'h00};
        vecs[4] = '{"over2049",   2049, 1, 33, 2048, 8'h01};
        vecs[5] = '{"stall5",     5,    1, 41, 5,    8'h00};

        reset         = 1'b1;
        log_en        = 1'b0;
        log_d         = 8'h00;
        log_frame_end = 1'b0;
        repeat (3) @(negedge clock);
        checkOutput("reset_out_valid",  32'(out_valid),  32'd0);
        checkOutput("reset_out_last",   32'(out_last),   32'd0);
        checkOutput("reset_out_d",      32'(out_d),      32'd0);
        checkOutput("reset_drop_count", 32'(drop_count), 32'd0);
        reset = 1'b0;

        // 64-byte frame whose first byte lands when the cycle counter reads 100.
        for (int c = 0; c < 300 && tbCycle < 99; c++) @(negedge clock);
        target = recordsDone + 1;
        applyStimulus(64, 0, ts);
        checkOutput("t1_ts_start", ts, 32'd100);
        waitRecords("t1", target);
        checkRecord("t1", 64, 8'h00, 32'd100, 0);

        foreach (vecs[v]) begin
            readyMode = vecs[v].stall;
            target    = recordsDone + 1;
            applyStimulus(vecs[v].frameLen, vecs[v].seed, ts);
            waitRecords(vecs[v].name, target);
            checkRecord(vecs[v].name, vecs[v].expLen, vecs[v].expFlags, ts, vecs[v].seed);
            readyMode = 0;
        end

        // A second frame arriving during DATA is dropped and flagged on the following record only.
        target = recordsDone + 1;
        applyStimulus(100, 50, ts);
        begin
            logic [31:0] tsA;
            logic [31:0] tsB;
            tsA = ts;
            waitBytes("t3_a", 20);
            applyStimulus(10, 60, tsB);
            waitRecords("t3_a", target);
            checkRecord("t3_a", 100, 8'h00, tsA, 50);
        end
        checkOutput("t3_drop_count_1", 32'(drop_count), 32'd1);

        target = recordsDone + 1;
        applyStimulus(30, 70, ts);
        begin
            logic [31:0] tsC;
            logic [31:0] tsS;
            tsC = ts;
            waitBytes("t3_c", 15);
            applyStimulus(1, 80, tsS);
            waitRecords("t3_c", target);
            checkRecord("t3_c", 30, 8'h02, tsC, 70);
        end
        checkOutput("t3_drop_count_2", 32'(drop_count), 32'd2);

        target = recordsDone + 1;
        applyStimulus(5, 90, ts);
        waitRecords("t3_d", target);
        checkRecord("t3_d", 5, 8'h02, ts, 90);

        target = recordsDone + 1;
        applyStimulus(5, 95, ts);
        waitRecords("t3_e", target);
        checkRecord("t3_e", 5, 8'h00, ts, 95);

        // Reset while header byte 3 is on the output abandons the record entirely.
        applyStimulus(20, 100, ts);
        repeat (3) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        checkOutput("t6_out_valid_after_reset", 32'(out_valid),  32'd0);
        checkOutput("t6_drop_count_reset",      32'(drop_count), 32'd0);
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        gotD.delete();
        gotL.delete();
        repeat (30) @(negedge clock);
        checkOutput("t6_no_leftover_bytes", 32'(gotD.size()), 32'd0);
        target = recordsDone + 1;
        applyStimulus(12, 110, ts);
        waitRecords("t6", target);
        checkRecord("t6", 12, 8'h00, ts, 110);

        $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
        $finish;
    end

endmodule
